// File: rtl/des1_pkg.sv
// Shared types and golden function for the des1 gate network: e = ~(a & b & ~c & ~d).
package des1_pkg;

  localparam int DES1_VEC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des1_chk_state_e;

  // vec bit order is {a,b,c,d}, MSB first.
  function automatic logic des1_expected(input logic [DES1_VEC_W-1:0] vec);
    return ~(vec[3] & vec[2] & ~vec[1] & ~vec[0]);
  endfunction

endpackage

// File: rtl/des1_ref.sv
// Combinational golden model of des1; zero latency, no flow control.
module des1_ref
  import des1_pkg::*;
(
  input  logic [DES1_VEC_W-1:0] vec,
  output logic                  e_exp
);

  assign e_exp = des1_expected(vec);

endmodule

// File: rtl/des1_chk.sv
// Response checker for des1: 2-cycle accept-to-count latency, vec_rdy drops after NUM_VEC beats or on start.
// Optional first-failing-vector capture under DES1_CHK_FIRSTFAIL_EN.
module des1_chk
  import des1_pkg::*;
#(
  parameter int NUM_VEC = 16,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  vec_vld,
  output logic                  vec_rdy,
  input  logic [DES1_VEC_W-1:0] vec_in,
  input  logic                  e_obs,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  mism,
  output logic [CNT_W-1:0]      vec_cnt,
  output logic [CNT_W-1:0]      fail_cnt
`ifdef DES1_CHK_FIRSTFAIL_EN
  ,
  output logic [DES1_VEC_W-1:0] first_fail_vec
`endif
);

  generate
    if (NUM_VEC < 1 || NUM_VEC > (2 ** CNT_W) - 1) begin : g_bad_num_vec
      $error("des1_chk: NUM_VEC must be in 1..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_VEC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  des1_chk_state_e       state_q;
  logic [CNT_W-1:0]      acc_cnt;
  logic                  s1_vld;
  logic [DES1_VEC_W-1:0] s1_vec;
  logic                  s1_e_obs;
  logic                  s2_e_exp;
  logic                  s2_mism;
  logic                  accept;

  // Ready never looks at vec_vld, so the generator may gate vld on rdy freely.
  assign vec_rdy = (state_q == RUN) && (acc_cnt < NUM_C) && !start;
  assign accept  = vec_vld && vec_rdy;

  des1_ref u_ref (
    .vec   (s1_vec),
    .e_exp (s2_e_exp)
  );

  assign s2_mism = s1_vld && (s1_e_obs != s2_e_exp);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = (state_q == DONE) && (fail_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_cnt  <= '0;
      s1_vld   <= 1'b0;
      s1_vec   <= '0;
      s1_e_obs <= 1'b0;
      mism     <= 1'b0;
      vec_cnt  <= '0;
      fail_cnt <= '0;
    end else if (start) begin
      // Restart from any state; the beat in stage 1 is dropped uncounted.
      state_q  <= RUN;
      acc_cnt  <= '0;
      s1_vld   <= 1'b0;
      mism     <= 1'b0;
      vec_cnt  <= '0;
      fail_cnt <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_vec   <= vec_in;
        s1_e_obs <= e_obs;
        acc_cnt  <= acc_cnt + CNT_W'(1);
      end
      mism <= s2_mism;
      if (s1_vld) begin
        vec_cnt <= sat_inc(vec_cnt);
        if (s2_mism) begin
          fail_cnt <= sat_inc(fail_cnt);
        end
        if (state_q == RUN && vec_cnt == LAST_C) begin
          state_q <= DONE;
        end
      end
    end
  end

`ifdef DES1_CHK_FIRSTFAIL_EN
  // fail_cnt is still zero only on the first mismatch of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vec <= '0;
    end else if (start) begin
      first_fail_vec <= '0;
    end else if (s2_mism && fail_cnt == '0) begin
      first_fail_vec <= s1_vec;
    end
  end
`endif

endmodule

// File: tb/tb_des1_chk.sv
// Directed bench for des1_chk: table-driven full runs plus restart, gap and async-reset sequences.
module tb_des1_chk;
  import des1_pkg::*;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start   = 1'b0;
  logic       vec_vld = 1'b0;
  logic [3:0] vec_in  = 4'h0;
  logic       e_obs   = 1'b0;
  logic       vec_rdy, busy, done, pass, mism;
  logic [7:0] vec_cnt, fail_cnt;
`ifdef DES1_CHK_FIRSTFAIL_EN
  logic [3:0] first_fail_vec;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] vec;
    logic       exp_e;
  } vec_t;
  vec_t tbl [16];

  des1_chk #(.NUM_VEC(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vec_vld  (vec_vld),
    .vec_rdy  (vec_rdy),
    .vec_in   (vec_in),
    .e_obs    (e_obs),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .mism     (mism),
    .vec_cnt  (vec_cnt),
    .fail_cnt (fail_cnt)
`ifdef DES1_CHK_FIRSTFAIL_EN
    ,
    .first_fail_vec (first_fail_vec)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    vec_vld = 1'b0;
    start   = 1'b1;
    #1;
    check("rdy_during_start", {31'd0, vec_rdy}, 0);
    tick();
    start = 1'b0;
    #1;
    check("start_vec_cnt", {24'd0, vec_cnt}, 0);
    check("start_fail_cnt", {24'd0, fail_cnt}, 0);
    check("start_busy", {31'd0, busy}, 1);
    check("start_rdy", {31'd0, vec_rdy}, 1);
  endtask

  // Streams all 16 table entries back to back; e_obs is the golden value xor inv.
  task automatic run_table(input logic [15:0] inv, input int exp_fails);
    int pulses = 0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        vec_vld = 1'b1;
        vec_in  = tbl[c].vec;
        e_obs   = tbl[c].exp_e ^ inv[c];
      end else begin
        vec_vld = 1'b0;
      end
      if (c >= 2) check("mism_cycle", {31'd0, mism}, {31'd0, inv[c-2]});
      else        check("mism_early", {31'd0, mism}, 0);
      if (mism) pulses++;
      if (c == 16) begin
        check("done_early", {31'd0, done}, 0);
        check("busy_before_end", {31'd0, busy}, 1);
      end
      if (c == 17) begin
        check("done_end", {31'd0, done}, 1);
        check("busy_end", {31'd0, busy}, 0);
        check("vec_cnt_end", {24'd0, vec_cnt}, 16);
        check("fail_cnt_end", {24'd0, fail_cnt}, exp_fails);
        check("pass_end", {31'd0, pass}, (exp_fails == 0) ? 1 : 0);
      end
      tick();
    end
    check("mism_pulses", pulses, exp_fails);
  endtask

  initial begin
    logic [15:0] gold;
    int sent;
    int cyc;

    // Golden e indexed by vector value: only 4'b1100 gives 0.
    gold = 16'hEFFF;
    for (int i = 0; i < 16; i++) begin
      tbl[i].vec   = 4'(15 - i);
      tbl[i].exp_e = gold[15 - i];
    end

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pass", {31'd0, pass}, 0);
    check("rst_mism", {31'd0, mism}, 0);
    check("rst_vec_cnt", {24'd0, vec_cnt}, 0);
    check("rst_fail_cnt", {24'd0, fail_cnt}, 0);
    check("rst_rdy", {31'd0, vec_rdy}, 0);
    tick();
    tick();
    rst_n   = 1'b1;
    vec_vld = 1'b1;
    tick();
    check("idle_rdy", {31'd0, vec_rdy}, 0);
    check("idle_busy", {31'd0, busy}, 0);

    // Clean run
    do_start();
    run_table(16'h0000, 0);

    // Single wrong response for 4'b1100 (table index 3)
    do_start();
    run_table(16'h0008, 1);
`ifdef DES1_CHK_FIRSTFAIL_EN
    check("ffv_single", {28'd0, first_fail_vec}, 32'hC);
`endif

    // Every response inverted
    do_start();
    run_table(16'hFFFF, 16);
`ifdef DES1_CHK_FIRSTFAIL_EN
    check("ffv_all", {28'd0, first_fail_vec}, 32'hF);
`endif

    // Random valid gaps, then a 17th beat offered
    do_start();
    sent = 0;
    cyc  = 0;
    while (sent < 16 && cyc < 400) begin
      vec_vld = ($urandom_range(0, 3) != 0);
      vec_in  = tbl[sent].vec;
      e_obs   = tbl[sent].exp_e;
      #1;
      if (vec_vld && vec_rdy) sent++;
      tick();
      cyc++;
    end
    check("gap_sent", sent, 16);
    vec_vld = 1'b1;
    vec_in  = 4'h0;
    e_obs   = 1'b1;
    #1;
    check("rdy_17th", {31'd0, vec_rdy}, 0);
    tick();
    tick();
    tick();
    vec_vld = 1'b0;
    check("gap_vec_cnt", {24'd0, vec_cnt}, 16);
    check("gap_done", {31'd0, done}, 1);
    check("gap_pass", {31'd0, pass}, 1);

    // Restart after 5 accepted beats with beats still in flight
    do_start();
    for (int c = 0; c < 5; c++) begin
      vec_vld = 1'b1;
      vec_in  = tbl[c].vec;
      e_obs   = ~tbl[c].exp_e;
      tick();
    end
    check("pre_restart_vec_cnt", {24'd0, vec_cnt}, 4);
    check("pre_restart_fail_cnt", {24'd0, fail_cnt}, 4);
    vec_in = tbl[5].vec;
    e_obs  = ~tbl[5].exp_e;
    start  = 1'b1;
    #1;
    check("restart_rdy", {31'd0, vec_rdy}, 0);
    tick();
    start   = 1'b0;
    vec_vld = 1'b0;
    #1;
    check("restart_vec_cnt", {24'd0, vec_cnt}, 0);
    check("restart_fail_cnt", {24'd0, fail_cnt}, 0);
    check("restart_mism", {31'd0, mism}, 0);
    check("restart_busy", {31'd0, busy}, 1);
`ifdef DES1_CHK_FIRSTFAIL_EN
    check("restart_ffv", {28'd0, first_fail_vec}, 0);
`endif
    tick();
    tick();
    check("no_ghost_vec_cnt", {24'd0, vec_cnt}, 0);
    check("no_ghost_fail_cnt", {24'd0, fail_cnt}, 0);
    run_table(16'h0000, 0);

    // Asynchronous reset mid-run
    do_start();
    for (int c = 0; c < 6; c++) begin
      vec_vld = 1'b1;
      vec_in  = tbl[c].vec;
      e_obs   = ~tbl[c].exp_e;
      tick();
    end
    check("pre_rst_vec_cnt", {24'd0, vec_cnt}, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_pass", {31'd0, pass}, 0);
    check("arst_mism", {31'd0, mism}, 0);
    check("arst_vec_cnt", {24'd0, vec_cnt}, 0);
    check("arst_fail_cnt", {24'd0, fail_cnt}, 0);
    check("arst_rdy", {31'd0, vec_rdy}, 0);
`ifdef DES1_CHK_FIRSTFAIL_EN
    check("arst_ffv", {28'd0, first_fail_vec}, 0);
`endif
    #2 rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      vec_vld = 1'b1;
      #1;
      check("post_rst_rdy", {31'd0, vec_rdy}, 0);
      check("post_rst_busy", {31'd0, busy}, 0);
      tick();
    end
    vec_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
